// File: rtl/vga_plot_arbiter_if.sv
// Shared VGA plot-port bundle: drawing engines on the master side, arbiter on the slave side.
interface vga_plot_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req;
    logic [9*NUM_REQ-1:0] x_in;
    logic [8*NUM_REQ-1:0] y_in;
    logic [6*NUM_REQ-1:0] colour_in;
    logic [NUM_REQ-1:0]   plot_in;
    logic [NUM_REQ-1:0]   grant;
    logic [8:0]           xOut;
    logic [7:0]           yOut;
    logic [5:0]           colourOut;
    logic                 plotOut;
    logic                 busy;

    modport master (
        output req, x_in, y_in, colour_in, plot_in,
        input  grant, xOut, yOut, colourOut, plotOut, busy
    );

    modport slave (
        input  req, x_in, y_in, colour_in, plot_in,
        output grant, xOut, yOut, colourOut, plotOut, busy
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the VGA adapter plot port, with an optional per-grant pixel budget
// that hands the port to a waiting engine once the owner has drawn MAX_PIXELS pixels.
module vga_plot_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int MAX_PIXELS = 0,
    parameter int CNT_W      = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    vga_plot_arbiter_if.slave io_bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, OWN} state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [8:0]         r_x;
    logic [7:0]         r_y;
    logic [5:0]         r_colour;
    logic               r_plot;
    logic               r_busy;

    logic [8:0]         w_x_arr [NUM_REQ];
    logic [7:0]         w_y_arr [NUM_REQ];
    logic [5:0]         w_c_arr [NUM_REQ];
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_cand;
    logic               w_accept;
    logic               w_others;
    logic               w_preempt;
    logic [CNT_W-1:0]   w_cnt_inc;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_x_arr[i] = io_bus.x_in[9*i +: 9];
            w_y_arr[i] = io_bus.y_in[8*i +: 8];
            w_c_arr[i] = io_bus.colour_in[6*i +: 6];
        end
    end

    // Search starts just after the last owner so every engine gets its turn.
    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_cand   = r_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && io_bus.req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_accept  = (r_state == OWN) && io_bus.req[r_ptr] && io_bus.plot_in[r_ptr];
    assign w_others  = |(io_bus.req & ~r_grant);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_preempt = (MAX_PIXELS != 0) && w_accept && w_others &&
                       (w_cnt_inc == CNT_W'(MAX_PIXELS));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_ptr    <= IDX_W'(NUM_REQ - 1);
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all updates see pre-edge values.
            r_plot <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= NUM_REQ'(1) << w_winner;
                        r_busy  <= 1'b1;
                        r_ptr   <= w_winner;
                        r_cnt   <= '0;
                        r_state <= OWN;
                    end
                end
                OWN: begin
                    if (!io_bus.req[r_ptr]) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_accept) begin
                        r_x      <= w_x_arr[r_ptr];
                        r_y      <= w_y_arr[r_ptr];
                        r_colour <= w_c_arr[r_ptr];
                        r_plot   <= 1'b1;
                        r_cnt    <= w_cnt_inc;
                        // The budget-ending pixel still goes out; the port frees at the same edge.
                        if (w_preempt) begin
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.grant     = r_grant;
    assign io_bus.xOut      = r_x;
    assign io_bus.yOut      = r_y;
    assign io_bus.colourOut = r_colour;
    assign io_bus.plotOut   = r_plot;
    assign io_bus.busy      = r_busy;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: a budgeted instance (MAX_PIXELS=4, 3-bit counter)
// and an unlimited instance, with a pixel scoreboard per instance.
module tb_vga_plot_arbiter;
    localparam int N = 3;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [5:0] c;
    } pix_t;

    logic   clk = 1'b0;
    logic   rst_n;
    int     total = 0;
    int     bad = 0;
    int     n_plot = 0;
    int     n_plot0 = 0;
    int     base;
    pix_t   exp_q[$];
    pix_t   exp0_q[$];
    pix_t   mp;
    pix_t   mp0;
    logic [N-1:0] prev_g = '0;
    logic [N-1:0] prev_g0 = '0;
    logic [N-1:0] one = 1;
    logic [N-1:0] eg;
    logic [5:0]   pat = 6'b101101;

    vga_plot_arbiter_if #(.NUM_REQ(N)) bus ();
    vga_plot_arbiter_if #(.NUM_REQ(N)) bus0 ();

    vga_plot_arbiter #(.NUM_REQ(N), .MAX_PIXELS(4), .CNT_W(3)) u_dut (
        .Clock(clk), .Resetn(rst_n), .io_bus(bus)
    );
    vga_plot_arbiter #(.NUM_REQ(N), .MAX_PIXELS(0), .CNT_W(16)) u_dut0 (
        .Clock(clk), .Resetn(rst_n), .io_bus(bus0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic pix_t mk(input int i, input int n);
        mk.x = 9'(n * 3 + 17 * i);
        mk.y = 8'(n + 40 * i);
        mk.c = 6'(n + 5 * i);
    endfunction

    task automatic put(input int i, input pix_t p, input bit expect_it);
        bus.x_in[9*i +: 9]      = p.x;
        bus.y_in[8*i +: 8]      = p.y;
        bus.colour_in[6*i +: 6] = p.c;
        if (expect_it) exp_q.push_back(p);
    endtask

    task automatic put0(input int i, input pix_t p, input bit expect_it);
        bus0.x_in[9*i +: 9]      = p.x;
        bus0.y_in[8*i +: 8]      = p.y;
        bus0.colour_in[6*i +: 6] = p.c;
        if (expect_it) exp0_q.push_back(p);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitors: grant exclusivity, busy, idle gap between owners, pixel scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check("onehot", 32'($onehot0(bus.grant)), 32'd1);
            check("busy", 32'(bus.busy), 32'(|bus.grant));
            if (prev_g != '0 && bus.grant != '0) check("handover", 32'(bus.grant), 32'(prev_g));
            prev_g = bus.grant;
            if (bus.plotOut) begin
                n_plot++;
                if (exp_q.size() == 0) check("spurious_plot", 32'(bus.plotOut), 32'd0);
                else begin
                    mp = exp_q.pop_front();
                    check("xOut", 32'(bus.xOut), 32'(mp.x));
                    check("yOut", 32'(bus.yOut), 32'(mp.y));
                    check("colourOut", 32'(bus.colourOut), 32'(mp.c));
                end
            end
        end else prev_g = '0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("onehot0", 32'($onehot0(bus0.grant)), 32'd1);
            check("busy0", 32'(bus0.busy), 32'(|bus0.grant));
            if (prev_g0 != '0 && bus0.grant != '0) check("handover0", 32'(bus0.grant), 32'(prev_g0));
            prev_g0 = bus0.grant;
            if (bus0.plotOut) begin
                n_plot0++;
                if (exp0_q.size() == 0) check("spurious_plot0", 32'(bus0.plotOut), 32'd0);
                else begin
                    mp0 = exp0_q.pop_front();
                    check("xOut0", 32'(bus0.xOut), 32'(mp0.x));
                    check("yOut0", 32'(bus0.yOut), 32'(mp0.y));
                    check("colourOut0", 32'(bus0.colourOut), 32'(mp0.c));
                end
            end
        end else prev_g0 = '0;
    end

    initial begin
        rst_n = 1'b0;
        bus.req = '0;  bus.plot_in = '0;  bus.x_in = '0;  bus.y_in = '0;  bus.colour_in = '0;
        bus0.req = '0; bus0.plot_in = '0; bus0.x_in = '0; bus0.y_in = '0; bus0.colour_in = '0;
        repeat (3) tick();

        // Reset values, then reset applied while owning.
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_plot", 32'(bus.plotOut), 32'd0);
        check("rst_x", 32'(bus.xOut), 32'd0);
        check("rst_y", 32'(bus.yOut), 32'd0);
        check("rst_colour", 32'(bus.colourOut), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        bus.req = 3'b010;
        tick();
        check("t1_first_grant", 32'(bus.grant), 32'(3'b010));
        bus.req = 3'b111;
        put(1, '{x: 9'd7, y: 8'd8, c: 6'd9}, 1'b1);
        bus.plot_in = 3'b010;
        tick();
        bus.plot_in = '0;
        check("t1_plot", 32'(bus.plotOut), 32'd1);
        check("t1_x", 32'(bus.xOut), 32'd7);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t1_midrst_grant", 32'(bus.grant), 32'd0);
        check("t1_midrst_plot", 32'(bus.plotOut), 32'd0);
        check("t1_midrst_x", 32'(bus.xOut), 32'd0);
        check("t1_midrst_busy", 32'(bus.busy), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("t1_regrant", 32'(bus.grant), 32'(3'b001));
        bus.req = '0;
        tick();
        check("t1_release", 32'(bus.grant), 32'd0);

        // Single requester, two pixels, then release.
        base = n_plot;
        bus.req = 3'b010;
        put(1, '{x: 9'd100, y: 8'd50, c: 6'h3F}, 1'b0);
        tick();
        check("t2_grant", 32'(bus.grant), 32'(3'b010));
        check("t2_noplot", 32'(bus.plotOut), 32'd0);
        bus.plot_in = 3'b010;
        exp_q.push_back('{x: 9'd100, y: 8'd50, c: 6'h3F});
        tick();
        check("t2_plot1", 32'(bus.plotOut), 32'd1);
        check("t2_x", 32'(bus.xOut), 32'd100);
        check("t2_y", 32'(bus.yOut), 32'd50);
        check("t2_c", 32'(bus.colourOut), 32'h3F);
        exp_q.push_back('{x: 9'd100, y: 8'd50, c: 6'h3F});
        tick();
        check("t2_plot2", 32'(bus.plotOut), 32'd1);
        bus.req = '0;
        bus.plot_in = '0;
        tick();
        check("t2_drop_grant", 32'(bus.grant), 32'd0);
        check("t2_drop_plot", 32'(bus.plotOut), 32'd0);
        check("t2_pulses", 32'(n_plot - base), 32'd2);

        // All requesting with continuous plotting: budget rotates the port every 4 pixels.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        base = n_plot;
        bus.req = 3'b111;
        bus.plot_in = 3'b111;
        for (int e = 1; e <= 16; e++) begin
            for (int i = 0; i < N; i++)
                put(i, mk(i, e), (((e - 1) % 5) >= 1) && (i == ((e - 1) / 5) % 3));
            tick();
            eg = (((e - 1) % 5) <= 3) ? (one << (((e - 1) / 5) % 3)) : '0;
            check($sformatf("t3_grant_e%0d", e), 32'(bus.grant), 32'(eg));
        end
        bus.req = '0;
        bus.plot_in = '0;
        tick();
        check("t3_release", 32'(bus.grant), 32'd0);
        check("t3_pulses", 32'(n_plot - base), 32'd12);

        // Requester 2 owns; strobes from 0 and 1 (and from anyone in IDLE) are ignored.
        base = n_plot;
        bus.req = 3'b100;
        bus.plot_in = 3'b011;
        tick();
        check("t5_grant", 32'(bus.grant), 32'(3'b100));
        check("t5_idle_plot", 32'(bus.plotOut), 32'd0);
        for (int k = 0; k < 6; k++) begin
            bus.plot_in = {pat[k], (k % 2 == 1), (k % 2 == 0)};
            for (int i = 0; i < N; i++) put(i, mk(i, 50 + k), (i == 2) && pat[k]);
            tick();
            check($sformatf("t5_grant_k%0d", k), 32'(bus.grant), 32'(3'b100));
        end
        bus.req = '0;
        bus.plot_in = '0;
        tick();
        check("t5_pulses", 32'(n_plot - base), 32'd4);

        // Lone owner passes its budget; late request must not preempt a saturated counter.
        base = n_plot;
        bus.req = 3'b010;
        tick();
        check("t6_grant", 32'(bus.grant), 32'(3'b010));
        bus.plot_in = 3'b011;
        for (int k = 0; k < 14; k++) begin
            if (k == 10) bus.req = 3'b011;
            for (int i = 0; i < N; i++) put(i, mk(i, 90 + k), i == 1);
            tick();
            check($sformatf("t6_hold_k%0d", k), 32'(bus.grant), 32'(3'b010));
        end
        bus.req = 3'b001;
        bus.plot_in = '0;
        tick();
        check("t6_release", 32'(bus.grant), 32'd0);
        tick();
        check("t6_next", 32'(bus.grant), 32'(3'b001));
        bus.req = '0;
        tick();
        check("t6_pulses", 32'(n_plot - base), 32'd14);

        // Unlimited budget: ten pixels with another request pending, no preemption.
        base = n_plot0;
        bus0.req = 3'b011;
        tick();
        check("t4_grant", 32'(bus0.grant), 32'(3'b001));
        bus0.plot_in = 3'b001;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) put0(i, mk(i, 120 + k), i == 0);
            tick();
            check($sformatf("t4_hold_k%0d", k), 32'(bus0.grant), 32'(3'b001));
        end
        bus0.req = 3'b010;
        bus0.plot_in = '0;
        tick();
        check("t4_release", 32'(bus0.grant), 32'd0);
        tick();
        check("t4_next", 32'(bus0.grant), 32'(3'b010));
        bus0.req = '0;
        tick();
        check("t4_pulses", 32'(n_plot0 - base), 32'd10);

        @(negedge clk);
        #1;
        check("q_empty", 32'(exp_q.size()), 32'd0);
        check("q0_empty", 32'(exp0_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single VGA adapter plot port (x, y, colour, plot) among NUM_REQ drawing engines, such as the car sprite drawer, the background eraser and the HUD/timer drawer.
- Uses round-robin arbitration with a req/grant handshake.
- An optional per-grant pixel budget lets a long-running engine be preempted so that other engines are not starved.
- Sits between the engines and vga_adapter; its registered outputs drive the adapter's x, y, colour and plot directly.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MAX_PIXELS, 0, pixels per grant before preemption when another request is pending. 0 = unlimited.
- CNT_W, 16, width of the pixel budget counter.

Ports:
- Clock  in  1  system clock (CLOCK_50).
- Resetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester ownership request, held high for the whole access.
- x_in  in  9*NUM_REQ  packed x coordinates; requester i uses [9i+8:9i].
- y_in  in  8*NUM_REQ  packed y coordinates; requester i uses [8i+7:8i].
- colour_in  in  6*NUM_REQ  packed colours; requester i uses [6i+5:6i].
- plot_in  in  NUM_REQ  per-requester pixel write strobe.
- grant  out  NUM_REQ  one-hot grant, registered.
- xOut  out  9  to the adapter x input.
- yOut  out  8  to the adapter y input.
- colourOut  out  6  to the adapter colour input.
- plotOut  out  1  to the adapter plot input.
- busy  out  1  high whenever any grant is active.

Behaviour:

Reset:
- Resetn low asynchronously clears grant, xOut, yOut, colourOut, plotOut, busy and the pixel counter.
- The round-robin pointer resets to NUM_REQ-1, so requester 0 wins first.
- The FSM resets to IDLE.

FSM states: IDLE, OWN.
- IDLE, any req bit high:
  - Select the first set bit searching from ptr+1 upward, with modular wrap.
  - At the next edge set grant to that one-hot bit, set ptr to the winner, clear the counter, and go to OWN.
  - Latency: req sampled at edge k gives grant high after edge k.
- IDLE, no req: stay in IDLE with grant at 0.
- OWN, owner g:
  - Pixel acceptance: a pixel is accepted in any cycle where grant[g], req[g] and plot_in[g] are all high.
  - Output on acceptance: at the next edge xOut/yOut/colourOut load requester g's slice and plotOut goes to 1. This is a 1-cycle registered latency.
  - Output with no acceptance: plotOut goes to 0 and xOut/yOut/colourOut hold their values.
  - Counter: increments on each accepted pixel and saturates at all-ones.
- OWN, release:
  - If req[g] is low at an edge, grant clears at that edge and the FSM returns to IDLE.
  - plot_in[g] in that cycle is ignored.
- OWN, preemption:
  - Applies only if MAX_PIXELS is nonzero.
  - Condition: the pixel accepted in this cycle makes the count equal MAX_PIXELS, and any other req bit is high.
  - That pixel is still output. grant clears at the same edge and the FSM goes to IDLE.
  - The preempted requester keeps req high. It must stall while grant is low and resume the same pixel stream when re-granted.
  - If no other req is pending, the owner keeps the grant and the counter saturates.
- Ignored inputs: plot_in from any non-granted requester is ignored, as is plot_in in IDLE. plotOut is never asserted from them.
- Handover cost: at least one IDLE cycle between grants, so grant is never high for two requesters at once. This is an assertion target.
- busy equals the OR of the grant bits.
- Simultaneous requests in IDLE resolve by round-robin only; there is no fixed priority.
- A req that drops during IDLE before being sampled is never granted.
- Reset mid-OWN: outputs drop immediately. The in-flight pixel is lost and the requester restarts after reset.

Test Plan (NUM_REQ=3, MAX_PIXELS=4 unless noted):
1. Reset applied while req=3'b111 and in OWN → grant=0, plotOut=0, xOut=0; after release, first grant=3'b001.
2. req=3'b010 alone, requester 1 plots (x=100, y=50, colour=6'h3F) for 2 cycles then drops req → grant=3'b010 one edge after req; plotOut high for exactly 2 cycles, each 1 cycle after plot_in; xOut=100, yOut=50; grant=0 the edge after req drops.
3. req=3'b111 held, each owner plotting continuously → grant sequence 001, 010, 100, 001 with one idle cycle between grants; exactly 4 plotOut pulses per grant.
4. MAX_PIXELS=0, req=3'b011, requester 0 plots 10 pixels then releases → no preemption; 10 plotOut pulses; grant moves to 3'b010.
5. Requester 2 granted; requesters 0 and 1 toggle plot_in without grant → plotOut reflects only requester 2's strobes and coordinates.
6. Owner reaches its 4th pixel with no other req pending → grant held; 5th and 6th pixels pass through; the counter saturates without wrapping.
